// File: rtl/shim_sts_pkg.sv
// Shared definitions for the SPI-domain status collector: fault codes and FSM states.
// No logic; constants and types only.
// Imported by the interface, the encoder and the top.
package shim_sts_pkg;

   localparam logic [3:0] FAULT_NONE          = 4'd0;
   localparam logic [3:0] FAULT_TRIG_BAD_CMD  = 4'd1;
   localparam logic [3:0] FAULT_TRIG_DATA_OVF = 4'd2;
   localparam logic [3:0] FAULT_DAC_BAD_CMD   = 4'd3;
   localparam logic [3:0] FAULT_DAC_CMD_UNF   = 4'd4;
   localparam logic [3:0] FAULT_DAC_DATA_OVF  = 4'd5;
   localparam logic [3:0] FAULT_ADC_BAD_CMD   = 4'd6;
   localparam logic [3:0] FAULT_ADC_CMD_UNF   = 4'd7;
   localparam logic [3:0] FAULT_ADC_DATA_OVF  = 4'd8;

   // Width of the first-fault channel field (covers NCH up to 8).
   localparam int CH_W = 3;

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      WAIT_HOLD = 2'd1,
      ACK       = 2'd2
   } sts_state_e;

endpackage

// File: rtl/shim_spi_sts_collect_if.sv
// Bundle of fault event inputs, clear handshake and sticky status outputs.
// master = event source / AXI-side clear requester, slave = the collector.
// Pure wiring; no timing of its own.
interface shim_spi_sts_collect_if #(
   parameter int NCH   = 8,
   parameter int CNT_W = 8
);
   import shim_sts_pkg::*;

   logic [NCH-1:0]   dac_ev_bad_cmd;
   logic [NCH-1:0]   dac_ev_cmd_underflow;
   logic [NCH-1:0]   dac_ev_data_overflow;
   logic [NCH-1:0]   adc_ev_bad_cmd;
   logic [NCH-1:0]   adc_ev_cmd_underflow;
   logic [NCH-1:0]   adc_ev_data_overflow;
   logic             trig_ev_bad_cmd;
   logic             trig_ev_data_overflow;
   logic             clr_req;
   logic             clr_ack;
   logic [NCH-1:0]   dac_bad_cmd_sts;
   logic [NCH-1:0]   dac_cmd_underflow_sts;
   logic [NCH-1:0]   dac_data_overflow_sts;
   logic [NCH-1:0]   adc_bad_cmd_sts;
   logic [NCH-1:0]   adc_cmd_underflow_sts;
   logic [NCH-1:0]   adc_data_overflow_sts;
   logic             trig_bad_cmd_sts;
   logic             trig_data_overflow_sts;
   logic             fault_any;
   logic [3:0]       first_fault_code;
   logic [CH_W-1:0]  first_fault_ch;
   logic [CNT_W-1:0] fault_count;

   modport master (
      output dac_ev_bad_cmd, dac_ev_cmd_underflow, dac_ev_data_overflow,
             adc_ev_bad_cmd, adc_ev_cmd_underflow, adc_ev_data_overflow,
             trig_ev_bad_cmd, trig_ev_data_overflow, clr_req,
      input  clr_ack, dac_bad_cmd_sts, dac_cmd_underflow_sts, dac_data_overflow_sts,
             adc_bad_cmd_sts, adc_cmd_underflow_sts, adc_data_overflow_sts,
             trig_bad_cmd_sts, trig_data_overflow_sts, fault_any,
             first_fault_code, first_fault_ch, fault_count
   );

   modport slave (
      input  dac_ev_bad_cmd, dac_ev_cmd_underflow, dac_ev_data_overflow,
             adc_ev_bad_cmd, adc_ev_cmd_underflow, adc_ev_data_overflow,
             trig_ev_bad_cmd, trig_ev_data_overflow, clr_req,
      output clr_ack, dac_bad_cmd_sts, dac_cmd_underflow_sts, dac_data_overflow_sts,
             adc_bad_cmd_sts, adc_cmd_underflow_sts, adc_data_overflow_sts,
             trig_bad_cmd_sts, trig_data_overflow_sts, fault_any,
             first_fault_code, first_fault_ch, fault_count
   );

endinterface

// File: rtl/shim_first_fault_enc.sv
// Priority encoder: picks the lowest fault code, then the lowest channel, among firing events.
// Combinational, zero latency.
// No backpressure; output follows inputs every cycle.
module shim_first_fault_enc
   import shim_sts_pkg::*;
#(
   parameter int NCH = 8
) (
   input  logic [NCH-1:0]  dac_bad_cmd,
   input  logic [NCH-1:0]  dac_cmd_unf,
   input  logic [NCH-1:0]  dac_data_ovf,
   input  logic [NCH-1:0]  adc_bad_cmd,
   input  logic [NCH-1:0]  adc_cmd_unf,
   input  logic [NCH-1:0]  adc_data_ovf,
   input  logic            trig_bad_cmd,
   input  logic            trig_data_ovf,
   output logic            valid,
   output logic [3:0]      code,
   output logic [CH_W-1:0] ch
);

   // Scan from lowest priority to highest so the last match (lowest code, lowest channel) wins.
   always_comb begin
      valid = 1'b0;
      code  = FAULT_NONE;
      ch    = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (adc_data_ovf[i]) begin valid = 1'b1; code = FAULT_ADC_DATA_OVF; ch = CH_W'(i); end
      end
      for (int i = NCH - 1; i >= 0; i--) begin
         if (adc_cmd_unf[i]) begin valid = 1'b1; code = FAULT_ADC_CMD_UNF; ch = CH_W'(i); end
      end
      for (int i = NCH - 1; i >= 0; i--) begin
         if (adc_bad_cmd[i]) begin valid = 1'b1; code = FAULT_ADC_BAD_CMD; ch = CH_W'(i); end
      end
      for (int i = NCH - 1; i >= 0; i--) begin
         if (dac_data_ovf[i]) begin valid = 1'b1; code = FAULT_DAC_DATA_OVF; ch = CH_W'(i); end
      end
      for (int i = NCH - 1; i >= 0; i--) begin
         if (dac_cmd_unf[i]) begin valid = 1'b1; code = FAULT_DAC_CMD_UNF; ch = CH_W'(i); end
      end
      for (int i = NCH - 1; i >= 0; i--) begin
         if (dac_bad_cmd[i]) begin valid = 1'b1; code = FAULT_DAC_BAD_CMD; ch = CH_W'(i); end
      end
      if (trig_data_ovf) begin valid = 1'b1; code = FAULT_TRIG_DATA_OVF; ch = '0; end
      if (trig_bad_cmd)  begin valid = 1'b1; code = FAULT_TRIG_BAD_CMD;  ch = '0; end
   end

endmodule

// File: rtl/shim_spi_sts_collect.sv
// Latches fault event pulses into sticky flags, records first fault and event count, clears via req/ack.
// Flags/fault_any/first_fault/count visible 1 cycle after the event; clr_ack 1 cycle after the clear.
// Clear is deferred until every flag has been stable MIN_HOLD cycles; events are never dropped.
module shim_spi_sts_collect
   import shim_sts_pkg::*;
#(
   parameter int NCH      = 8,
   parameter int MIN_HOLD = 4,
   parameter int CNT_W    = 8
) (
   input logic                   clk,
   input logic                   rst,
   shim_spi_sts_collect_if.slave bus
);

   localparam int HOLD_W = (MIN_HOLD > 2) ? $clog2(MIN_HOLD) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(MIN_HOLD - 1);

   sts_state_e      state;
   logic [HOLD_W-1:0] hold_cnt;
   logic            req_seen_low;   // clr_req observed low since reset; blocks a stale request
   logic            do_clr;
   logic            hold_zero;
   logic            rise;
   logic            any_nx;

   logic [NCH-1:0]  dac_bad_nx, dac_unf_nx, dac_ovf_nx;
   logic [NCH-1:0]  adc_bad_nx, adc_unf_nx, adc_ovf_nx;
   logic            trig_bad_nx, trig_ovf_nx;

   logic            ev_vld;
   logic [3:0]      ev_code;
   logic [CH_W-1:0] ev_ch;

   assign hold_zero = (hold_cnt == '0);
   assign do_clr    = bus.clr_req && hold_zero &&
                      (((state == RUN) && req_seen_low) || (state == WAIT_HOLD));

   // An event coinciding with a clear survives it.
   assign dac_bad_nx  = (bus.dac_bad_cmd_sts       & ~{NCH{do_clr}}) | bus.dac_ev_bad_cmd;
   assign dac_unf_nx  = (bus.dac_cmd_underflow_sts & ~{NCH{do_clr}}) | bus.dac_ev_cmd_underflow;
   assign dac_ovf_nx  = (bus.dac_data_overflow_sts & ~{NCH{do_clr}}) | bus.dac_ev_data_overflow;
   assign adc_bad_nx  = (bus.adc_bad_cmd_sts       & ~{NCH{do_clr}}) | bus.adc_ev_bad_cmd;
   assign adc_unf_nx  = (bus.adc_cmd_underflow_sts & ~{NCH{do_clr}}) | bus.adc_ev_cmd_underflow;
   assign adc_ovf_nx  = (bus.adc_data_overflow_sts & ~{NCH{do_clr}}) | bus.adc_ev_data_overflow;
   assign trig_bad_nx = (bus.trig_bad_cmd_sts       & ~do_clr) | bus.trig_ev_bad_cmd;
   assign trig_ovf_nx = (bus.trig_data_overflow_sts & ~do_clr) | bus.trig_ev_data_overflow;

   assign rise = (|(dac_bad_nx & ~bus.dac_bad_cmd_sts))       |
                 (|(dac_unf_nx & ~bus.dac_cmd_underflow_sts)) |
                 (|(dac_ovf_nx & ~bus.dac_data_overflow_sts)) |
                 (|(adc_bad_nx & ~bus.adc_bad_cmd_sts))       |
                 (|(adc_unf_nx & ~bus.adc_cmd_underflow_sts)) |
                 (|(adc_ovf_nx & ~bus.adc_data_overflow_sts)) |
                 (trig_bad_nx & ~bus.trig_bad_cmd_sts)        |
                 (trig_ovf_nx & ~bus.trig_data_overflow_sts);

   assign any_nx = (|dac_bad_nx) | (|dac_unf_nx) | (|dac_ovf_nx) |
                   (|adc_bad_nx) | (|adc_unf_nx) | (|adc_ovf_nx) |
                   trig_bad_nx | trig_ovf_nx;

   shim_first_fault_enc #(.NCH(NCH)) u_enc (
      .dac_bad_cmd   (bus.dac_ev_bad_cmd),
      .dac_cmd_unf   (bus.dac_ev_cmd_underflow),
      .dac_data_ovf  (bus.dac_ev_data_overflow),
      .adc_bad_cmd   (bus.adc_ev_bad_cmd),
      .adc_cmd_unf   (bus.adc_ev_cmd_underflow),
      .adc_data_ovf  (bus.adc_ev_data_overflow),
      .trig_bad_cmd  (bus.trig_ev_bad_cmd),
      .trig_data_ovf (bus.trig_ev_data_overflow),
      .valid         (ev_vld),
      .code          (ev_code),
      .ch            (ev_ch)
   );

   // Sticky flags and their OR, registered together so they always agree.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.dac_bad_cmd_sts        <= '0;
         bus.dac_cmd_underflow_sts  <= '0;
         bus.dac_data_overflow_sts  <= '0;
         bus.adc_bad_cmd_sts        <= '0;
         bus.adc_cmd_underflow_sts  <= '0;
         bus.adc_data_overflow_sts  <= '0;
         bus.trig_bad_cmd_sts       <= 1'b0;
         bus.trig_data_overflow_sts <= 1'b0;
         bus.fault_any              <= 1'b0;
      end else begin
         bus.dac_bad_cmd_sts        <= dac_bad_nx;
         bus.dac_cmd_underflow_sts  <= dac_unf_nx;
         bus.dac_data_overflow_sts  <= dac_ovf_nx;
         bus.adc_bad_cmd_sts        <= adc_bad_nx;
         bus.adc_cmd_underflow_sts  <= adc_unf_nx;
         bus.adc_data_overflow_sts  <= adc_ovf_nx;
         bus.trig_bad_cmd_sts       <= trig_bad_nx;
         bus.trig_data_overflow_sts <= trig_ovf_nx;
         bus.fault_any              <= any_nx;
      end
   end

   // Hold timer: restarts on any flag change so the AXI synchronizers always see a stable level.
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_cnt <= '0;
      end else if (rise || do_clr) begin
         hold_cnt <= HOLD_LOAD;
      end else if (!hold_zero) begin
         hold_cnt <= hold_cnt - 1'b1;
      end
   end

   // First-fault capture; a clear re-arms it, taking a same-cycle event if present.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.first_fault_code <= FAULT_NONE;
         bus.first_fault_ch   <= '0;
      end else if (do_clr) begin
         bus.first_fault_code <= ev_vld ? ev_code : FAULT_NONE;
         bus.first_fault_ch   <= ev_vld ? ev_ch : '0;
      end else if ((bus.first_fault_code == FAULT_NONE) && ev_vld) begin
         bus.first_fault_code <= ev_code;
         bus.first_fault_ch   <= ev_ch;
      end
   end

   // Saturating count of cycles carrying at least one event.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.fault_count <= '0;
      end else if (do_clr) begin
         bus.fault_count <= ev_vld ? CNT_W'(1) : '0;
      end else if (ev_vld && (bus.fault_count != '1)) begin
         bus.fault_count <= bus.fault_count + CNT_W'(1);
      end
   end

   // Clear handshake FSM; clr_ack is a registered output of the state transition.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= RUN;
         bus.clr_ack  <= 1'b0;
         req_seen_low <= 1'b0;
      end else begin
         if (!bus.clr_req) begin
            req_seen_low <= 1'b1;
         end
         case (state)
            RUN: begin
               if (bus.clr_req && req_seen_low) begin
                  if (hold_zero) begin
                     state       <= ACK;
                     bus.clr_ack <= 1'b1;
                  end else begin
                     state <= WAIT_HOLD;
                  end
               end
            end
            WAIT_HOLD: begin
               if (!bus.clr_req) begin
                  state <= RUN;
               end else if (hold_zero) begin
                  state       <= ACK;
                  bus.clr_ack <= 1'b1;
               end
            end
            ACK: begin
               if (!bus.clr_req) begin
                  state       <= RUN;
                  bus.clr_ack <= 1'b0;
               end
            end
            default: begin
               state       <= RUN;
               bus.clr_ack <= 1'b0;
            end
         endcase
      end
   end

endmodule
